alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Two-byte-instruction sequencer that fetches opcode/operand bytes from memory
// and drives an external combinational ALU, writing the result into ACC.
module alu_seq (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start_in,
   output logic       mem_req_out,
   output logic [7:0] mem_addr_out,
   input  logic       mem_ack_in,
   input  logic [7:0] mem_data_in,
   output logic [2:0] unit_sel_out,
   output logic       op_sel_out,
   output logic [7:0] acc_out,
   output logic [7:0] src_out,
   input  logic [7:0] alu_res_in,
   output logic       busy_out,
   output logic       halted_out
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_OP,
      FETCH_ARG,
      EXEC,
      HALT
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] pc;
   logic [7:0] acc;
   logic [3:0] ir;
   logic [7:0] src;
   logic       fetch_done;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      mem_req_out = 1'b0;
      busy_out    = 1'b0;
      halted_out  = 1'b0;
      fetch_done  = 1'b0;
      case (state)
         IDLE: begin
            if (start_in) next_state = FETCH_OP;
         end
         FETCH_OP: begin
            mem_req_out = 1'b1;
            busy_out    = 1'b1;
            fetch_done  = mem_ack_in;
            if (mem_ack_in) begin
               next_state = (mem_data_in[7:4] == 4'b1111) ? HALT : FETCH_ARG;
            end
         end
         FETCH_ARG: begin
            mem_req_out = 1'b1;
            busy_out    = 1'b1;
            fetch_done  = mem_ack_in;
            if (mem_ack_in) next_state = EXEC;
         end
         EXEC: begin
            busy_out   = 1'b1;
            next_state = FETCH_OP;
         end
         HALT: begin
            halted_out = 1'b1;
            if (start_in) next_state = FETCH_OP;
         end
         default: next_state = IDLE;
      endcase
   end

   // Only the upper nibble of the opcode is ever decoded, so only it is kept.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc  <= 8'h00;
         acc <= 8'h00;
         ir  <= 4'h0;
         src <= 8'h00;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start_in) begin
                  pc  <= 8'h00;
                  acc <= 8'h00;
               end
            end
            FETCH_OP: begin
               if (fetch_done) begin
                  ir <= mem_data_in[7:4];
                  pc <= pc + 8'd1;
               end
            end
            FETCH_ARG: begin
               if (fetch_done) begin
                  src <= mem_data_in;
                  pc  <= pc + 8'd1;
               end
            end
            EXEC: begin
               if (ir[3:1] != 3'b111) begin
                  acc <= alu_res_in;
               end else if (!ir[0] && (acc != 8'h00)) begin
                  pc <= src;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr_out = pc;
   assign unit_sel_out = ir[3:1];
   assign op_sel_out   = ir[0];
   assign acc_out      = acc;
   assign src_out      = src;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: behavioural program memory with wait states,
// a small reference ALU, a vector table and hand-written corner-case sequences.
module tb_alu_seq;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       start_in;
   logic       mem_req_out;
   logic [7:0] mem_addr_out;
   logic       mem_ack_in;
   logic [7:0] mem_data_in;
   logic [2:0] unit_sel_out;
   logic       op_sel_out;
   logic [7:0] acc_out;
   logic [7:0] src_out;
   logic [7:0] alu_res_in;
   logic       busy_out;
   logic       halted_out;

   logic [7:0] mem [256];
   int         wait_states = 0;
   int         wait_cnt = 0;
   logic       spurious_ack = 1'b0;

   int         tests = 0;
   int         fails = 0;

   int         busy_cycles = 0;
   int         sub_execs = 0;
   int         stable_err = 0;
   logic       aa_seen = 1'b0;
   logic [7:0] ack_log[$];
   logic [7:0] acc_log[$];
   logic       prev_req = 1'b0;
   logic       prev_ack = 1'b0;
   logic [7:0] prev_addr = 8'h00;
   logic [7:0] prev_acc = 8'h00;

   typedef struct {
      logic [7:0] pre;
      logic [7:0] op;
      logic [7:0] src;
      logic [7:0] exp_acc;
      logic [7:0] exp_pc;
   } vec_t;

   vec_t vecs[13];

   alu_seq dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .start_in     (start_in),
      .mem_req_out  (mem_req_out),
      .mem_addr_out (mem_addr_out),
      .mem_ack_in   (mem_ack_in),
      .mem_data_in  (mem_data_in),
      .unit_sel_out (unit_sel_out),
      .op_sel_out   (op_sel_out),
      .acc_out      (acc_out),
      .src_out      (src_out),
      .alu_res_in   (alu_res_in),
      .busy_out     (busy_out),
      .halted_out   (halted_out)
   );

   always #5 clk_in = ~clk_in;

   // Memory answers after wait_states idle request cycles; ack lands in the final one.
   assign mem_ack_in  = spurious_ack | (mem_req_out & (wait_cnt >= wait_states));
   assign mem_data_in = mem[mem_addr_out];

   always @(posedge clk_in) begin
      if (rst_in || !mem_req_out || mem_ack_in) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   // Reference ALU; unit 7 returns a marker so a wrongful ACC write is visible.
   always_comb begin
      alu_res_in = 8'hEE;
      case ({unit_sel_out, op_sel_out})
         4'b0000: alu_res_in = acc_out + src_out;
         4'b0001: alu_res_in = acc_out - src_out;
         4'b0010: alu_res_in = acc_out & src_out;
         4'b0011: alu_res_in = acc_out | src_out;
         4'b0100: alu_res_in = acc_out << src_out[2:0];
         4'b0101: alu_res_in = acc_out >> src_out[2:0];
         4'b0110: alu_res_in = src_out;
         4'b0111: alu_res_in = src_out;
         default: alu_res_in = 8'hEE;
      endcase
   end

   // Observation of cycle counts, fetch addresses, ACC history and request stability.
   always @(negedge clk_in) begin
      if (busy_out) busy_cycles <= busy_cycles + 1;
      if (busy_out && !mem_req_out && unit_sel_out == 3'd0 && op_sel_out)
         sub_execs <= sub_execs + 1;
      if (mem_req_out && mem_ack_in) ack_log.push_back(mem_addr_out);
      if (acc_out != prev_acc) acc_log.push_back(acc_out);
      if (acc_out == 8'hAA) aa_seen <= 1'b1;
      if (!rst_in && prev_req && !prev_ack &&
          (!mem_req_out || mem_addr_out != prev_addr))
         stable_err <= stable_err + 1;
      prev_req  <= mem_req_out;
      prev_ack  <= mem_ack_in;
      prev_addr <= mem_addr_out;
      prev_acc  <= acc_out;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
   endtask

   // Pulses start for one cycle from an idle/halted DUT and clears observers.
   task automatic applyStimulus(input int ws);
      @(negedge clk_in);
      wait_states = ws;
      busy_cycles = 0;
      sub_execs   = 0;
      stable_err  = 0;
      aa_seen     = 1'b0;
      ack_log.delete();
      acc_log.delete();
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic waitHalt(input string name, input int budget);
      for (int i = 0; i < budget && !halted_out; i++) @(negedge clk_in);
      checkOutput({name, "_halted"}, halted_out, 1'b1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req"}, mem_req_out, 1'b0);
      checkOutput({tag, "_addr"}, mem_addr_out, 8'h00);
      checkOutput({tag, "_unit"}, unit_sel_out, 3'd0);
      checkOutput({tag, "_op"}, op_sel_out, 1'b0);
      checkOutput({tag, "_acc"}, acc_out, 8'h00);
      checkOutput({tag, "_src"}, src_out, 8'h00);
      checkOutput({tag, "_busy"}, busy_out, 1'b0);
      checkOutput({tag, "_halted"}, halted_out, 1'b0);
   endtask

   task automatic loadCountdown();
      clearMem();
      mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h01;
      mem[4] = 8'hE0; mem[5] = 8'h02; mem[6] = 8'hF0;
   endtask

   initial begin
      vecs[0]  = '{8'h10, 8'h00, 8'h05, 8'h15, 8'h05};
      vecs[1]  = '{8'hF0, 8'h00, 8'h20, 8'h10, 8'h05};
      vecs[2]  = '{8'h05, 8'h10, 8'h01, 8'h04, 8'h05};
      vecs[3]  = '{8'h00, 8'h10, 8'h01, 8'hFF, 8'h05};
      vecs[4]  = '{8'h81, 8'h40, 8'h01, 8'h02, 8'h05};
      vecs[5]  = '{8'h80, 8'h50, 8'h03, 8'h10, 8'h05};
      vecs[6]  = '{8'h12, 8'h60, 8'hAB, 8'hAB, 8'h05};
      vecs[7]  = '{8'hF0, 8'h20, 8'h3C, 8'h30, 8'h05};
      vecs[8]  = '{8'hF0, 8'h30, 8'h0F, 8'hFF, 8'h05};
      vecs[9]  = '{8'h00, 8'h6F, 8'h5A, 8'h5A, 8'h05};
      vecs[10] = '{8'h00, 8'hE0, 8'h40, 8'h00, 8'h05};
      vecs[11] = '{8'h07, 8'hE0, 8'h40, 8'h07, 8'h41};
      vecs[12] = '{8'h01, 8'hE5, 8'h20, 8'h01, 8'h21};

      rst_in   = 1'b1;
      start_in = 1'b0;
      clearMem();
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      checkResetOutputs("reset");

      // Ack with no request outstanding must not move the machine out of IDLE.
      spurious_ack = 1'b1;
      @(negedge clk_in);
      spurious_ack = 1'b0;
      @(negedge clk_in);
      checkOutput("spur_ack_busy", busy_out, 1'b0);
      checkOutput("spur_ack_addr", mem_addr_out, 8'h00);
      checkOutput("spur_ack_acc", acc_out, 8'h00);
      checkOutput("spur_ack_halted", halted_out, 1'b0);

      loadCountdown();
      applyStimulus(0);
      waitHalt("countdown", 200);
      checkOutput("countdown_acc", acc_out, 8'h00);
      checkOutput("countdown_pc", mem_addr_out, 8'h07);
      checkOutput("countdown_sub_execs", sub_execs, 5);
      checkOutput("countdown_busy_cycles", busy_cycles, 34);
      checkOutput("halt_req", mem_req_out, 1'b0);
      checkOutput("halt_busy", busy_out, 1'b0);

      loadCountdown();
      applyStimulus(3);
      waitHalt("countdown_ws", 600);
      checkOutput("countdown_ws_acc", acc_out, 8'h00);
      checkOutput("countdown_ws_pc", mem_addr_out, 8'h07);
      checkOutput("countdown_ws_sub_execs", sub_execs, 5);
      checkOutput("countdown_ws_busy_cycles", busy_cycles, 103);
      checkOutput("countdown_ws_stable", stable_err, 0);

      clearMem();
      mem[0] = 8'h60; mem[1] = 8'h81; mem[2] = 8'h40; mem[3] = 8'h01;
      mem[4] = 8'h50; mem[5] = 8'h03; mem[6] = 8'hF0;
      applyStimulus(0);
      waitHalt("shifter", 200);
      checkOutput("shifter_acc_changes", acc_log.size(), 3);
      checkOutput("shifter_acc0", acc_log[0], 8'h81);
      checkOutput("shifter_acc1", acc_log[1], 8'h02);
      checkOutput("shifter_acc2", acc_log[2], 8'h00);
      checkOutput("shifter_pc", mem_addr_out, 8'h07);

      // Each vector runs "60 pre; op src; F0" restarting from HALT.
      for (int v = 0; v < 13; v++) begin
         clearMem();
         mem[0] = 8'h60; mem[1] = vecs[v].pre;
         mem[2] = vecs[v].op; mem[3] = vecs[v].src;
         applyStimulus(v % 3);
         waitHalt($sformatf("vec%0d", v), 200);
         checkOutput($sformatf("vec%0d_acc", v), acc_out, vecs[v].exp_acc);
         checkOutput($sformatf("vec%0d_pc", v), mem_addr_out, vecs[v].exp_pc);
      end

      // Branch to 0xFE, run an instruction across the PC wrap, halt at 0x00.
      clearMem();
      mem[0] = 8'h60; mem[1] = 8'h01; mem[2] = 8'hE0; mem[3] = 8'hFE;
      mem[8'hFE] = 8'h60; mem[8'hFF] = 8'h33;
      applyStimulus(0);
      for (int i = 0; i < 50 && !(mem_req_out && mem_addr_out == 8'hFE); i++)
         @(negedge clk_in);
      checkOutput("wrap_reached_fe", mem_addr_out, 8'hFE);
      mem[0] = 8'hF0;
      waitHalt("wrap", 100);
      checkOutput("wrap_acc", acc_out, 8'h33);
      checkOutput("wrap_pc", mem_addr_out, 8'h01);
      checkOutput("wrap_fetches", ack_log.size(), 7);
      checkOutput("wrap_fetch_ff", ack_log[5], 8'hFF);
      checkOutput("wrap_fetch_00", ack_log[6], 8'h00);

      // start_in during a wait-stated operand fetch must be ignored.
      clearMem();
      mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h01;
      applyStimulus(2);
      for (int i = 0; i < 50 && !(mem_req_out && mem_addr_out == 8'h03); i++)
         @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      checkOutput("spur_start_addr", mem_addr_out, 8'h03);
      checkOutput("spur_start_busy", busy_out, 1'b1);
      waitHalt("spur_start", 200);
      checkOutput("spur_start_acc", acc_out, 8'h06);
      checkOutput("spur_start_pc", mem_addr_out, 8'h05);
      checkOutput("spur_start_fetches", ack_log.size(), 5);

      // Reset lands on the EXEC edge of "60 AA".
      clearMem();
      mem[0] = 8'h60; mem[1] = 8'hAA;
      applyStimulus(0);
      for (int i = 0; i < 20 && !(busy_out && !mem_req_out); i++)
         @(negedge clk_in);
      checkOutput("midexec_in_exec", busy_out && !mem_req_out, 1'b1);
      rst_in = 1'b1;
      @(negedge clk_in);
      checkResetOutputs("midexec");
      rst_in = 1'b0;
      @(negedge clk_in);
      checkOutput("midexec_never_aa", aa_seen, 1'b0);

      // Reset wins over a simultaneous start.
      rst_in   = 1'b1;
      start_in = 1'b1;
      @(negedge clk_in);
      rst_in   = 1'b0;
      start_in = 1'b0;
      checkOutput("rst_prio_busy", busy_out, 1'b0);
      checkOutput("rst_prio_req", mem_req_out, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
